// File: rtl/watch_pkg.sv
// Shared watch types and helpers: BCD digit type, digit maximum, and
// binary-to-BCD / digit-validity functions used by the counter blocks.
package watch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Two-digit packed BCD {tens, ones} for a value in 0..99.
    function automatic logic [7:0] bin2bcd(input int v);
        bcd_t t;
        bcd_t o;
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic bcd_valid(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/watch_bcd_digit.sv
// One BCD digit (0..9) with increment/decrement, terminal-count flags and
// parallel load; digits are chained by gating the next digit's inc/dec.
module watch_bcd_digit
    import watch_pkg::*;
#(
    parameter bcd_t RST_VAL = 4'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic tc_up,
    output logic tc_dn
);

    bcd_t q_q;
    bcd_t q_d;

    assign tc_up = (q_q == BCD_MAX);
    assign tc_dn = (q_q == 4'd0);
    assign q     = q_q;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_val;
        end else if (inc) begin
            q_d = tc_up ? 4'd0 : q_q + 4'd1;
        end else if (dec) begin
            q_d = tc_dn ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/watch_bcd_counter.sv
// Two-digit BCD watch counter LOW..HIGH with wrap carry/borrow and optional
// time-set preset, enabled by defining WATCH_BCD_LOAD_EN.
module watch_bcd_counter
    import watch_pkg::*;
#(
    parameter int LOW  = 0,
    parameter int HIGH = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry,
    output logic       load_err
);

    generate
        if (LOW < 0 || LOW > 98 || HIGH <= LOW || HIGH > 99) begin : g_bad_params
            $error("watch_bcd_counter: illegal LOW/HIGH parameters");
        end
    endgenerate

    localparam logic [7:0] LOW_BCD  = bin2bcd(LOW);
    localparam logic [7:0] HIGH_BCD = bin2bcd(HIGH);

    bcd_t tens_q;
    bcd_t ones_q;
    logic ones_tc_up;
    logic ones_tc_dn;
    logic tens_tc_up_unused;
    logic tens_tc_dn_unused;

    logic load_req;
    logic load_ok;
    logic at_high;
    logic at_low;

    logic ld;
    bcd_t ld_tens;
    bcd_t ld_ones;
    logic inc;
    logic dec;
    logic carry_d;
    logic carry_q;
    logic err_d;
    logic err_q;

`ifdef WATCH_BCD_LOAD_EN
    assign load_req = load;
    assign load_ok  = bcd_valid(load_tens) && bcd_valid(load_ones) &&
                      ({load_tens, load_ones} >= LOW_BCD) &&
                      ({load_tens, load_ones} <= HIGH_BCD);
`else
    logic unused_load;
    assign unused_load = ^{load, load_tens, load_ones};
    assign load_req    = 1'b0;
    assign load_ok     = 1'b0;
`endif

    // Digits always hold valid BCD, so packed BCD compares order like integers.
    assign at_high = ({tens_q, ones_q} == HIGH_BCD);
    assign at_low  = ({tens_q, ones_q} == LOW_BCD);

    always_comb begin
        ld      = 1'b0;
        ld_tens = LOW_BCD[7:4];
        ld_ones = LOW_BCD[3:0];
        inc     = 1'b0;
        dec     = 1'b0;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (load_req) begin
            if (load_ok) begin
                ld      = 1'b1;
                ld_tens = load_tens;
                ld_ones = load_ones;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick) begin
            if (up_dn) begin
                if (at_high) begin
                    ld      = 1'b1;
                    carry_d = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end else begin
                if (at_low) begin
                    ld      = 1'b1;
                    ld_tens = HIGH_BCD[7:4];
                    ld_ones = HIGH_BCD[3:0];
                    carry_d = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
        end
    end

    watch_bcd_digit #(
        .RST_VAL(LOW_BCD[3:0])
    ) u_ones (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .ld    (ld),
        .ld_val(ld_ones),
        .q     (ones_q),
        .tc_up (ones_tc_up),
        .tc_dn (ones_tc_dn)
    );

    watch_bcd_digit #(
        .RST_VAL(LOW_BCD[7:4])
    ) u_tens (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc & ones_tc_up),
        .dec   (dec & ones_tc_dn),
        .ld    (ld),
        .ld_val(ld_tens),
        .q     (tens_q),
        .tc_up (tens_tc_up_unused),
        .tc_dn (tens_tc_dn_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign carry    = carry_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_watch_bcd_counter.sv
// Randomized bench for watch_bcd_counter (0..59 and 1..12 instances) against an
// integer reference model; honours WATCH_BCD_LOAD_EN like the design.
module tb_watch_bcd_counter;

`ifdef WATCH_BCD_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;

    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic       carry_a, err_a, carry_b, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    watch_bcd_counter u_dut_a (
        .clk(clk), .rst(rst), .tick(tick), .up_dn(up_dn), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_a), .ones(ones_a), .carry(carry_a), .load_err(err_a)
    );

    watch_bcd_counter #(.LOW(1), .HIGH(12)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick), .up_dn(up_dn), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_b), .ones(ones_b), .carry(carry_b), .load_err(err_b)
    );

    // Reference model: plain integer value per instance.
    int lo [2] = '{0, 1};
    int hi [2] = '{59, 12};
    int mv [2];
    bit mc [2];
    bit me [2];

    function automatic logic [8:0] model_next(input int v, input int l, input int h);
        int  nv;
        int  lv;
        bit  c;
        bit  e;
        nv = v;
        c  = 1'b0;
        e  = 1'b0;
        if (LOAD_EN && load) begin
            lv = int'(load_tens) * 10 + int'(load_ones);
            if (load_tens <= 9 && load_ones <= 9 && lv >= l && lv <= h) nv = lv;
            else e = 1'b1;
        end else if (tick) begin
            if (up_dn) begin
                if (v == h) begin nv = l; c = 1'b1; end
                else nv = v + 1;
            end else begin
                if (v == l) begin nv = h; c = 1'b1; end
                else nv = v - 1;
            end
        end
        return {e, c, 7'(nv)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mv[i] <= lo[i];
                mc[i] <= 1'b0;
                me[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mv[i] <= int'(model_next(mv[i], lo[i], hi[i]) & 9'h07f);
                mc[i] <= model_next(mv[i], lo[i], hi[i])[7];
                me[i] <= model_next(mv[i], lo[i], hi[i])[8];
            end
        end
    end

    function automatic logic [9:0] exp_of(input int i);
        return {4'(mv[i] / 10), 4'(mv[i] % 10), mc[i], me[i]};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got tens=%h ones=%h carry=%b err=%b, expected tens=%h ones=%h carry=%b err=%b",
                     name, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        check("model_a", {tens_a, ones_a, carry_a, err_a}, exp_of(0));
        check("model_b", {tens_b, ones_b, carry_b, err_b}, exp_of(1));
    end

    task automatic drive(input bit t, input bit ud, input bit ld, input logic [3:0] lt, input logic [3:0] lo_d);
        tick      = t;
        up_dn     = ud;
        load      = ld;
        load_tens = lt;
        load_ones = lo_d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [3:0] t, input logic [3:0] o, input bit c, input bit e);
        check(name, {tens_a, ones_a, carry_a, err_a}, {t, o, c, e});
    endtask

    task automatic chk_b(input string name, input logic [3:0] t, input logic [3:0] o, input bit c, input bit e);
        check(name, {tens_b, ones_b, carry_b, err_b}, {t, o, c, e});
    endtask

    initial begin
        int ncar;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_a("reset_a", 4'd0, 4'd0, 1'b0, 1'b0);
        chk_b("reset_b", 4'd0, 4'd1, 1'b0, 1'b0);
        rst = 1'b1;

        // 60 up ticks: 00..59 then 00 with one carry at the wrap.
        ncar = 0;
        for (int i = 1; i <= 60; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
            if (carry_a) ncar++;
            if (i == 59) chk_a("up_to_59", 4'd5, 4'd9, 1'b0, 1'b0);
        end
        chk_a("wrap_59_00", 4'd0, 4'd0, 1'b1, 1'b0);
        chk_b("wrap_12_01", 4'd0, 4'd1, 1'b1, 1'b0);
        check("carry_count", 10'(ncar), 10'd1);

        // Down wrap at LOW, then plain decrement without carry.
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_b("down_01_12", 4'd1, 4'd2, 1'b1, 1'b0);
        chk_a("down_00_59", 4'd5, 4'd9, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_b("down_12_11", 4'd1, 4'd1, 1'b0, 1'b0);
        chk_a("down_59_58", 4'd5, 4'd8, 1'b0, 1'b0);

        if (LOAD_EN) begin
            drive(1'b1, 1'b1, 1'b1, 4'd2, 4'd5);
            chk_a("load_tick_25", 4'd2, 4'd5, 1'b0, 1'b0);
            chk_b("load_oor_b", 4'd1, 4'd1, 1'b0, 1'b1);
            drive(1'b0, 1'b1, 1'b1, 4'd3, 4'd7);
            chk_a("load_37", 4'd3, 4'd7, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b1, 4'd6, 4'd0);
            chk_a("load_60_err", 4'd3, 4'd7, 1'b0, 1'b1);
            drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
            chk_a("err_one_cycle", 4'd3, 4'd7, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd10);
            chk_b("load_bad_digit", 4'd1, 4'd1, 1'b0, 1'b1);
            drive(1'b0, 1'b1, 1'b1, 4'd1, 4'd2);
            chk_b("load_12_b", 4'd1, 4'd2, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
            chk_a("reach_09", 4'd0, 4'd9, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 1'b1, 4'd1, 4'd0);
            chk_a("noload_tick_10", 4'd1, 4'd0, 1'b0, 1'b0);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9)));
        end

        // Async reset between edges at 59 with tick pending.
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_a("pre_rst_59", 4'd5, 4'd9, 1'b1, 1'b0);
        tick  = 1'b1;
        up_dn = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_a("async_rst_a", 4'd0, 4'd0, 1'b0, 1'b0);
        chk_b("async_rst_b", 4'd0, 4'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_a("held_in_rst", 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_a("first_after_rst", 4'd0, 4'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
